// File: rtl/button_conditioner.sv
// Three-channel sync + debounce + edge detect; pulses appear 2 + DEBOUNCE_CYCLES clocks after a raw edge, no backpressure.
// Define BTN_LONG_PRESS_EN to add the channel-0 long-press detector and suppress the release that ends a long hold.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int LONG_CYCLES     = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn_in,
  output logic [2:0] btn_level,
  output logic [2:0] btn_press,
  output logic [2:0] btn_release,
  output logic       long_press
);

  localparam int NCH = 3;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  generate
    if (DEBOUNCE_CYCLES < 2 ||
        longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W) - 1 ||
        LONG_CYCLES < 2 ||
        longint'(LONG_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_params
      $error("button_conditioner: counts do not fit the CNT_W-bit counters");
    end
  endgenerate

  logic   [NCH-1:0]            sync1_q;
  logic   [NCH-1:0]            sync2_q;
  state_t [NCH-1:0]            state_q;
  state_t [NCH-1:0]            state_d;
  logic   [NCH-1:0][CNT_W-1:0] cnt_q;
  logic   [NCH-1:0][CNT_W-1:0] cnt_d;
  logic   [NCH-1:0]            level_q;
  logic   [NCH-1:0]            level_d;
  logic   [NCH-1:0]            press_q;
  logic   [NCH-1:0]            press_d;
  logic   [NCH-1:0]            release_q;
  logic   [NCH-1:0]            release_d;
  logic   [NCH-1:0]            release_acc;
  logic                        long_q;
  logic                        long_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    press_d     = '0;
    release_acc = '0;
    for (int c = 0; c < NCH; c++) begin
      case (state_q[c])
        IDLE: begin
          if (sync2_q[c]) begin
            cnt_d[c]   = CNT_W'(1);
            state_d[c] = PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[c]) begin
            cnt_d[c]   = '0;
            state_d[c] = IDLE;
          end else if (cnt_q[c] == DB_LAST) begin
            cnt_d[c]   = '0;
            state_d[c] = PRESSED;
            level_d[c] = 1'b1;
            press_d[c] = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!sync2_q[c]) begin
            cnt_d[c]   = CNT_W'(1);
            state_d[c] = RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q[c]) begin
            cnt_d[c]   = '0;
            state_d[c] = PRESSED;
          end else if (cnt_q[c] == DB_LAST) begin
            cnt_d[c]       = '0;
            state_d[c]     = IDLE;
            level_d[c]     = 1'b0;
            release_acc[c] = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        default: begin
          cnt_d[c]   = '0;
          state_d[c] = IDLE;
        end
      endcase
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_d;
  logic             fired_q;
  logic             fired_d;

  // Hold time keeps accumulating through release bounces; it only restarts from IDLE.
  always_comb begin
    hold_d    = hold_q;
    fired_d   = fired_q;
    long_d    = 1'b0;
    release_d = release_acc;
    if (state_q[0] == PRESSED || state_q[0] == RELEASE_WAIT) begin
      if (hold_q == HOLD_LAST) begin
        if (!fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
      end else begin
        hold_d = hold_q + CNT_W'(1);
      end
    end else begin
      hold_d  = '0;
      fired_d = 1'b0;
    end
    if (fired_q || long_d) begin
      release_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      fired_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      fired_q <= fired_d;
    end
  end
`else
  always_comb begin
    long_d    = 1'b0;
    release_d = release_acc;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= {NCH{IDLE}};
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign long_press  = long_q;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the stopwatch controller and counter-clear logic.
- Takes three raw, asynchronous, bouncing push-button inputs: start/stop, lap, clear.
- Per button it synchronises, debounces and edge-detects the input, then emits clean single-cycle pulses and stable levels in the 1 MHz system clock domain.
- Downstream toggle logic consumes only these pulses, so no raw pad ever drives a clock pin.

Parameters:
- DEBOUNCE_CYCLES, 10000: consecutive stable synchronised cycles required to accept a level change (10 ms at 1 MHz). Legal range 2..2^CNT_W-1.
- LONG_CYCLES, 1000000: cycles channel 0 must stay debounced-high to count as a long press (1 s). Used only with BTN_LONG_PRESS_EN.
- CNT_W, 20: width of every per-channel counter. Must hold the larger of the two counts above.

Ports:
- clk, input, 1: system clock, 1 MHz.
- rst_n, input, 1: reset, asynchronous, active-low.
- btn_in, input, 3: raw buttons, active-high. [0] start_stop, [1] lap_time, [2] clear.
- btn_level, output, 3: debounced level per channel.
- btn_press, output, 3: one-cycle pulse on each accepted 0->1 transition.
- btn_release, output, 3: one-cycle pulse on each accepted 1->0 transition.
- long_press, output, 1: one-cycle pulse when channel 0 is held for LONG_CYCLES. Constant 0 unless the optional feature is compiled in.

Behaviour:
- Reset (async assert, sync deassert via clk): clears all synchroniser flops, counters, states and outputs to 0.
  - A button held through reset release is seen as a fresh press after debounce.
- Channels are fully independent. Simultaneous activity on several channels produces pulses in the same cycle with no priority.
- Synchroniser: 2 flops per channel. s = second flop output.
- Per-channel FSM; cnt is a CNT_W-bit counter.
  - IDLE (level 0): if s==1, cnt<=1 and go to PRESS_WAIT.
  - PRESS_WAIT: if s==0, go to IDLE (bounce, cnt<=0). Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED, set btn_level=1, assert btn_press for one cycle, cnt<=0. Else cnt++.
  - PRESSED (level 1): if s==0, cnt<=1 and go to RELEASE_WAIT.
  - RELEASE_WAIT: if s==1, go back to PRESSED (bounce). Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE, set btn_level=0, assert btn_release for one cycle. Else cnt++.
- Latency: raw edge sampled at clk edge k gives btn_press/btn_release high during the cycle after edge k+1+DEBOUNCE_CYCLES, i.e. 2 sync + DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse and no btn_level change.
- Pulses are registered outputs, exactly one cycle wide, and never on consecutive cycles for the same channel.
- The counter never wraps: every wait state exits at DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: BTN_LONG_PRESS_EN.
- Defined: channel 0 gets a hold counter that runs while in PRESSED or RELEASE_WAIT.
  - btn_press[0] is still emitted at press acceptance.
  - When the hold counter reaches LONG_CYCLES-1, long_press pulses once, and the counter saturates until the next IDLE.
  - The btn_release[0] that ends a long hold is suppressed, so downstream can treat release-after-short-press as the only "short" event.
- Not defined: no hold counter, long_press tied to 0, btn_release[0] is never suppressed.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20):
- Clean press: btn_in[0] 0->1 and held 10 cycles -> btn_press[0] high exactly 1 cycle, 6 clocks after the first sampling edge; btn_level[0]=1 from the same cycle; no other outputs.
- Bounce: btn_in[1] toggles 1,0,1,0 every cycle, then stays 1 -> exactly one btn_press[1], 6 cycles after the final rising sample; stays 1 -> 0 with a 3-cycle low glitch gives no btn_release.
- Simultaneous: btn_in[0] and btn_in[2] rise on the same edge -> btn_press[0] and btn_press[2] pulse in the same cycle; btn_press[1]=0.
- Reset mid-debounce: rst_n low for 1 cycle during PRESS_WAIT with the button still held -> all outputs 0 immediately (async); a press pulse follows 6 cycles after rst_n deasserts.
- Release: after an accepted press, btn_in[0] falls and stays low -> btn_release[0] pulses once, 6 cycles later; btn_level[0]=0.
- Long press (BTN_LONG_PRESS_EN): hold btn_in[0] for 40 cycles, then release -> one btn_press[0], one long_press 20 cycles after btn_press[0], no btn_release[0]. Without the macro, long_press stays 0 and btn_release[0] pulses.
